// File: rtl/crc_two_pkg.sv
// Shared constants, state encoding and the serial division step for the
// 7-bit (3 data + 4 CRC) codeword link, generator x^4+x^2+x+1.
package crc_two_pkg;

   localparam logic [4:0] GPE       = 5'b10111;
   localparam int         DATA_W    = 3;
   localparam int         CRC_W     = 4;
   localparam int         FRAME_LEN = DATA_W + CRC_W;

   typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

   // One bit of polynomial division. The x^n term of the generator is implicit.
   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r,
                                                 input logic             b,
                                                 input logic [CRC_W-1:0] poly);
      logic fb;
      fb = r[CRC_W-1] ^ b;
      return {r[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
   endfunction

endpackage

// File: rtl/crc_serial_lfsr.sv
// Serial CRC division register: one bit per enabled clock, optional clear
// so the first bit of a frame divides from a zero remainder.
module crc_serial_lfsr
   import crc_two_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY = GPE[CRC_W-1:0]
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             data,
   output logic [CRC_W-1:0] r
);

   always_ff @(posedge clk) begin
      if (reset)
         r <= '0;
      else if (enable)
         r <= crc_step(clear ? '0 : r, data, POLY);
   end

endmodule

// File: rtl/crc_check_two.sv
// Receive-side CRC checker: recovers the data bits of each codeword, flags
// the frame good/bad and keeps a saturating bad-frame count.
module crc_check_two #(
   parameter logic [crc_two_pkg::CRC_W:0] GPE = crc_two_pkg::GPE,
   parameter int                          ERR_CNT_W = 8
) (
   input  logic                                i_clk,
   input  logic                                i_reset,
   input  logic                                i_data,
   input  logic                                i_valid,
   input  logic                                i_sof,
   output logic [crc_two_pkg::DATA_W-1:0]      o_data,
   output logic                                o_done,
   output logic                                o_crc_ok,
   output logic                                o_crc_err,
   output logic                                o_busy,
   output logic [ERR_CNT_W-1:0]                o_err_cnt
);
   import crc_two_pkg::*;

   localparam int                CNT_W    = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0]  DATA_END = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0]  LAST     = CNT_W'(FRAME_LEN);

   state_t              state, state_next;
   logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc;
   logic [DATA_W-1:0]   sreg;
   logic [CRC_W-1:0]    rem;
   logic                lfsr_en, lfsr_clr, shift_en, frame_end, ok_next;

   crc_serial_lfsr #(.POLY(GPE[CRC_W-1:0])) u_lfsr (
      .clk    (i_clk),
      .reset  (i_reset),
      .clear  (lfsr_clr),
      .enable (lfsr_en),
      .data   (i_data),
      .r      (rem)
   );

   // A sof bit restarts the frame from any state, which also covers abort.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      cnt_inc    = cnt + 1'b1;
      lfsr_en    = 1'b0;
      lfsr_clr   = 1'b0;
      shift_en   = 1'b0;
      frame_end  = 1'b0;
      if (i_valid) begin
         if (i_sof) begin
            state_next = DATA;
            cnt_next   = CNT_W'(1);
            lfsr_en    = 1'b1;
            lfsr_clr   = 1'b1;
            shift_en   = 1'b1;
         end else begin
            case (state)
               DATA: begin
                  lfsr_en  = 1'b1;
                  shift_en = 1'b1;
                  cnt_next = cnt_inc;
                  if (cnt_inc == DATA_END) state_next = CRC;
               end
               CRC: begin
                  lfsr_en  = 1'b1;
                  cnt_next = cnt_inc;
                  if (cnt_inc == LAST) begin
                     frame_end  = 1'b1;
                     state_next = IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Verdict uses the remainder including the bit being sampled now.
   assign ok_next = (crc_step(rem, i_data, GPE[CRC_W-1:0]) == '0);

   always_ff @(posedge i_clk) begin
      if (i_reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt       <= '0;
         sreg      <= '0;
         o_data    <= '0;
         o_done    <= 1'b0;
         o_crc_ok  <= 1'b0;
         o_crc_err <= 1'b0;
         o_busy    <= 1'b0;
         o_err_cnt <= '0;
      end else begin
         cnt    <= cnt_next;
         o_done <= frame_end;
         o_busy <= (state_next != IDLE);
         if (shift_en)
            sreg <= {sreg[DATA_W-2:0], i_data};
         if (frame_end) begin
            o_data    <= sreg;
            o_crc_ok  <= ok_next;
            o_crc_err <= !ok_next;
            if (!ok_next && (o_err_cnt != '1))
               o_err_cnt <= o_err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_crc_check_two.sv
// Directed bench for crc_check_two; a second instance with a 2-bit error
// counter shares the stimulus to exercise saturation.
module tb_crc_check_two;

   logic       clk = 1'b0;
   logic       reset, data, valid, sof;
   logic [2:0] o_data, o_data2;
   logic       o_done, o_ok, o_err, o_busy;
   logic       o_done2, o_ok2, o_err2, o_busy2;
   logic [7:0] o_cnt;
   logic [1:0] o_cnt2;

   int         tests = 0;
   int         fails = 0;
   int         ndone = 0;
   logic [6:0] cw;

   always #5 clk = ~clk;

   crc_check_two dut (
      .i_clk(clk), .i_reset(reset), .i_data(data), .i_valid(valid), .i_sof(sof),
      .o_data(o_data), .o_done(o_done), .o_crc_ok(o_ok), .o_crc_err(o_err),
      .o_busy(o_busy), .o_err_cnt(o_cnt)
   );

   crc_check_two #(.ERR_CNT_W(2)) dut2 (
      .i_clk(clk), .i_reset(reset), .i_data(data), .i_valid(valid), .i_sof(sof),
      .o_data(o_data2), .o_done(o_done2), .o_crc_ok(o_ok2), .o_crc_err(o_err2),
      .o_busy(o_busy2), .o_err_cnt(o_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then look at the registered outputs 1 ns later.
   task automatic step(input logic v, input logic s, input logic d);
      valid = v; sof = s; data = d;
      @(posedge clk);
      #1;
      if (o_done) ndone++;
   endtask

   task automatic frame(input logic [6:0] w);
      for (int i = 6; i >= 0; i--) step(1'b1, i == 6, w[i]);
   endtask

   initial begin
      reset = 1'b1; valid = 1'b0; sof = 1'b0; data = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", o_data, 0);
      chk("rst_done", o_done, 0);
      chk("rst_ok", o_ok, 0);
      chk("rst_err", o_err, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_cnt", o_cnt, 0);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0);

      // Good frame 101_1100, busy rises after the sof bit
      ndone = 0;
      step(1'b1, 1'b1, 1'b1);
      chk("f1_busy_rise", o_busy, 1);
      chk("f1_no_early_done", o_done, 0);
      cw = 7'b1011100;
      for (int i = 5; i >= 0; i--) step(1'b1, 1'b0, cw[i]);
      chk("f1_done", o_done, 1);
      chk("f1_ndone", ndone, 1);
      chk("f1_data", o_data, 3'b101);
      chk("f1_ok", o_ok, 1);
      chk("f1_err", o_err, 0);
      chk("f1_cnt", o_cnt, 0);
      chk("f1_busy_fall", o_busy, 0);

      // Back-to-back 011_1001 then 001_0111, second sof while done is high
      frame(7'b0111001);
      chk("b2b1_done", o_done, 1);
      chk("b2b1_data", o_data, 3'b011);
      chk("b2b1_ok", o_ok, 1);
      ndone = 0;
      frame(7'b0010111);
      chk("b2b2_ndone", ndone, 1);
      chk("b2b2_done", o_done, 1);
      chk("b2b2_data", o_data, 3'b001);
      chk("b2b2_ok", o_ok, 1);
      chk("b2b2_cnt", o_cnt, 0);

      // Every single-bit flip of 101_1100 must be flagged
      for (int k = 0; k < 7; k++) begin
         cw = 7'b1011100 ^ (7'd1 << k);
         frame(cw);
         chk("flip_done", o_done, 1);
         chk("flip_err", o_err, 1);
         chk("flip_ok", o_ok, 0);
         chk("flip_data", o_data, cw[6:4]);
         chk("flip_cnt", o_cnt, k + 1);
         chk("flip_cnt_sat", o_cnt2, (k + 1 > 3) ? 3 : k + 1);
      end

      // 011_1001 with random gaps; sof/data toggle while valid is low
      ndone = 0;
      cw = 7'b0111001;
      step(1'b1, 1'b1, cw[6]);
      for (int i = 5; i >= 0; i--) begin
         repeat ($urandom_range(0, 5)) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("gap_busy", o_busy, 1);
         end
         step(1'b1, 1'b0, cw[i]);
      end
      chk("gap_ndone", ndone, 1);
      chk("gap_done", o_done, 1);
      chk("gap_data", o_data, 3'b011);
      chk("gap_ok", o_ok, 1);
      chk("gap_cnt", o_cnt, 7);

      // Valid bits without sof while idle are discarded; results hold
      ndone = 0;
      repeat (3) step(1'b1, 1'b0, 1'b1);
      chk("stray_busy", o_busy, 0);
      chk("stray_ndone", ndone, 0);
      chk("stray_hold_data", o_data, 3'b011);
      chk("stray_hold_ok", o_ok, 1);
      chk("stray_cnt", o_cnt, 7);

      // Abort after 4 bits, restart with 101_1100
      ndone = 0;
      cw = 7'b0111001;
      for (int i = 6; i >= 3; i--) step(1'b1, i == 6, cw[i]);
      frame(7'b1011100);
      chk("abort_ndone", ndone, 1);
      chk("abort_data", o_data, 3'b101);
      chk("abort_ok", o_ok, 1);
      chk("abort_cnt", o_cnt, 7);
      chk("abort_cnt_sat", o_cnt2, 3);

      // Reset mid-frame
      ndone = 0;
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      reset = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      chk("mid_rst_ndone", ndone, 0);
      chk("mid_rst_data", o_data, 0);
      chk("mid_rst_ok", o_ok, 0);
      chk("mid_rst_err", o_err, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_cnt", o_cnt, 0);
      chk("mid_rst_cnt2", o_cnt2, 0);
      reset = 1'b0;
      step(1'b1, 1'b0, 1'b1);
      chk("post_rst_ndone", ndone, 0);
      chk("post_rst_busy", o_busy, 0);
      frame(7'b1011100);
      chk("post_rst_ok", o_ok, 1);
      chk("post_rst_data", o_data, 3'b101);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/crc_check_two.md
# crc_check_two

Serial CRC checker and data extractor for the 7-bit CRC codeword stream (3 data bits followed by 4 CRC bits, generator x^4+x^2+x+1, GPE 5'b10111). It sits at the receive end of the serial CRC link. It strips the 3 data bits into a parallel word, divides the whole codeword by the generator, and flags each frame as good or corrupted. It also keeps a saturating count of bad frames.

## Interface
- GPE, 5'b10111, generator polynomial, MSB = x^4 term
- DATA_W, 3, data bits per codeword
- CRC_W, 4, CRC bits per codeword; must equal width(GPE)-1
- ERR_CNT_W, 8, width of bad-frame counter
- i_clk  input  1  clock, all logic on rising edge
- i_reset  input  1  synchronous reset, active-high
- i_data  input  1  serial codeword bit
- i_valid  input  1  i_data is sampled on this edge only when high
- i_sof  input  1  qualifies i_valid; marks first bit of a codeword
- o_data  output  DATA_W  recovered data word, first received bit = MSB
- o_done  output  1  one-cycle pulse: frame complete, results valid
- o_crc_ok  output  1  last completed frame had zero remainder
- o_crc_err  output  1  last completed frame had nonzero remainder
- o_busy  output  1  frame in progress
- o_err_cnt  output  ERR_CNT_W  saturating count of bad frames

## Operation
- Bit order: data MSB first, then CRC remainder MSB first. For example, data 3'b101 gives codeword 101_1100.
- Serial division register r[CRC_W-1:0]. For each accepted bit b: fb = r[3]^b; r <= {r[2:0],1'b0} ^ (fb ? GPE[3:0] : 0).
- States:
  - IDLE: o_busy=0. i_valid&i_sof clears r, applies the first bit, sets bit count=1, and moves to DATA.
  - DATA: accepted bits shift into the data shift register and into r. After bit DATA_W, go to CRC.
  - CRC: accepted bits go into r only. On bit DATA_W+CRC_W (the 7th), do all of the following on that same edge, then return to IDLE:
    - load o_data from the shift register
    - set o_crc_ok = (next r == 0) and o_crc_err = its inverse
    - pulse o_done
    - increment o_err_cnt if the frame is bad
- i_valid low: hold all state. Gaps of any length are allowed inside a frame.
- i_valid without i_sof in IDLE: bit is discarded, and the bad-frame count is unchanged.
- i_sof with i_valid mid-frame: abort the current frame with no o_done and no count change, and restart with this bit as bit 1.
- o_data, o_crc_ok and o_crc_err hold their values until the next o_done.
- o_err_cnt saturates at all-ones and does not wrap.

## Timing
- Reset values: o_data=0, o_done=0, o_crc_ok=0, o_crc_err=0, o_busy=0, o_err_cnt=0, state=IDLE, r=0.
- Latency: results and the o_done pulse are visible in the cycle after the edge that samples the 7th bit.
- o_busy:
  - rises the cycle after the sof bit is sampled
  - falls together with the o_done pulse
- Back-to-back frames: a sof bit may arrive on the cycle o_done is high. It is accepted, with no dead cycle.
- i_reset has priority over everything. Reset mid-frame discards the partial frame and does not pulse o_done.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package crc_two_pkg holds:
  - GPE, DATA_W, CRC_W and FRAME_LEN = DATA_W+CRC_W
  - the state enum (IDLE, DATA, CRC)
- Sub-module crc_serial_lfsr: a single-bit division step with inputs clear, enable and bit, and output r. It is shared with future encoder rework.
- Top-level contents: FSM, bit counter, data shift register, result and counter registers.

## Test plan
- Reset release, then codeword 101_1100 with i_valid held high and sof on the first bit:
  - o_done pulses 1 cycle after the 7th bit
  - o_data=3'b101, o_crc_ok=1, o_err_cnt=0
- Codewords 011_1001 and 001_0111 back-to-back, sof on the cycle of the first frame's o_done:
  - two o_done pulses, 7 cycles apart
  - o_data 3'b011 then 3'b001, both ok
- Codeword 101_1101 (last bit flipped): o_crc_err=1, o_err_cnt=1. Repeat the check with each single-bit flip position; all 7 flips must be flagged bad.
- Codeword 011_1001 with random i_valid gaps of 0–5 cycles: same result as the gap-free case, and o_busy stays high across the gaps.
- Abort and reset:
  - A new sof after 4 bits of a frame, followed by 101_1100: exactly one o_done, and the frame is ok.
  - i_reset mid-frame: no o_done, and all outputs return to their reset values.
- With ERR_CNT_W overridden to 2, send 5 bad frames: o_err_cnt reads 1,2,3,3,3.
